// File: rtl/ifu_decode_pkg.sv
// Shared decode definitions: instruction format classes, bus types and base opcodes.
package ifu_decode_pkg;

    localparam int TYPE_W = 3;
    localparam int REG_W  = 5;

    typedef logic [TYPE_W-1:0] type_bus_t;
    typedef logic [REG_W-1:0]  reg_bus_t;

    localparam type_bus_t INST_R = 3'd0;
    localparam type_bus_t INST_I = 3'd1;
    localparam type_bus_t INST_S = 3'd2;
    localparam type_bus_t INST_B = 3'd3;
    localparam type_bus_t INST_U = 3'd4;
    localparam type_bus_t INST_J = 3'd5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0,x0,0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_decode_inst_classify.sv
// Maps an instruction's opcode and register fields to its format class and the
// RV32E legality flag. Purely combinational so the difftest checker can reuse it.
module ifu_decode_inst_classify
    import ifu_decode_pkg::*;
(
    input  logic [6:0] opcode,
    input  reg_bus_t   rd,
    input  reg_bus_t   rs1,
    input  reg_bus_t   rs2,
    output type_bus_t  type3,
    output logic       illegal
);

    logic use_rd;
    logic use_rs1;
    logic use_rs2;
    logic bad_op;
    logic unused_lo;

    always_comb begin
        type3   = INST_R;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_op  = 1'b0;
        case (opcode)
            OP_REG: ;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                type3   = INST_I;
                use_rs2 = 1'b0;
            end
            OP_STORE: begin
                type3  = INST_S;
                use_rd = 1'b0;
            end
            OP_BRANCH: begin
                type3  = INST_B;
                use_rd = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                type3   = INST_U;
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
            OP_JAL: begin
                type3   = INST_J;
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
            default: bad_op = 1'b1;
        endcase
    end

    // RV32E only has x0..x15, so bit 4 of any register index the format uses is fatal
    assign illegal = bad_op | (use_rd & rd[4]) | (use_rs1 & rs1[4]) | (use_rs2 & rs2[4]);

    assign unused_lo = ^{rd[3:0], rs1[3:0], rs2[3:0]};

endmodule

// File: rtl/ifu_decode.sv
// Fetch stage of the multicycle RV32E core: owns the PC, fetches one instruction
// at a time and presents the latched word and its fields until downstream takes it.
//
// state   | meaning
// FETCH   | request pending on imem, imem_addr = pc
// WAIT    | request accepted, waiting for response or timeout
// HOLD    | instruction latched, out_valid high until out_ready
module ifu_decode
    import ifu_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output reg_bus_t    rs1,
    output reg_bus_t    rs2,
    output reg_bus_t    rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output type_bus_t   type3,
    output logic        illegal,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             npc_lo_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_FETCH;
            pc             <= RESET_PC;
            inst           <= INST_NOP;
            out_valid      <= 1'b0;
            imem_req_valid <= 1'b1;
            fetch_err      <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                        wait_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // a response on the last allowed cycle still wins over the timeout
                    if (imem_rsp_valid) begin
                        inst      <= imem_rsp_data;
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        inst      <= INST_NOP;
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        pc             <= {npc[31:2], 2'b00};
                        state          <= S_FETCH;
                        out_valid      <= 1'b0;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_FETCH;
                    out_valid      <= 1'b0;
                    imem_req_valid <= 1'b1;
                end
            endcase
        end
    end

    // misaligned targets are flagged downstream; the low bits are simply dropped here
    assign npc_lo_unused = ^npc[1:0];

    assign imem_addr = pc;
    assign rd        = inst[11:7];
    assign funct3    = inst[14:12];
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign funct7    = inst[31:25];

    ifu_decode_inst_classify u_classify (
        .opcode  (inst[6:0]),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .type3   (type3),
        .illegal (illegal)
    );

endmodule

// File: tb/tb_ifu_decode.sv
// Self-checking bench for ifu_decode: vector table, hand-written corner sequences
// and randomized transactions against a transaction-level reference model.
module tb_ifu_decode;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                        7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    localparam logic [2:0] OPT [10] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                        3'd2, 3'd3, 3'd4, 3'd4, 3'd5};

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] npc, pc, inst;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [2:0]  type3;
    logic        illegal, fetch_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic        exp_err;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  t;
        logic        il;
    } vec_t;

    vec_t vecs [15];

    ifu_decode #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .npc(npc),
        .pc(pc), .inst(inst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7), .type3(type3), .illegal(illegal),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference classification: table lookup of the opcode, then the set of
    // register fields each format actually names.
    function automatic void ref_class(input logic [31:0] w, output logic [2:0] t, output logic il);
        logic found = 1'b0;
        logic u_rd, u_rs1, u_rs2;
        t = T_R;
        for (int i = 0; i < 10; i++)
            if (w[6:0] == OPS[i]) begin
                t = OPT[i];
                found = 1'b1;
            end
        u_rd  = !(t == T_S || t == T_B);
        u_rs1 = (t == T_R || t == T_I || t == T_S || t == T_B);
        u_rs2 = (t == T_R || t == T_S || t == T_B);
        il = !found || (u_rd && w[11]) || (u_rs1 && w[19]) || (u_rs2 && w[24]);
    endfunction

    task automatic check_hold(input logic [31:0] ei, input logic [2:0] et, input logic eil,
                              input logic [31:0] epc, input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " req_valid_hold"}, 32'(imem_req_valid), 32'd0);
        chk({tag, " inst"}, inst, ei);
        chk({tag, " pc"}, pc, epc);
        chk({tag, " rd"}, 32'(rd), 32'(ei[11:7]));
        chk({tag, " rs1"}, 32'(rs1), 32'(ei[19:15]));
        chk({tag, " rs2"}, 32'(rs2), 32'(ei[24:20]));
        chk({tag, " funct3"}, 32'(funct3), 32'(ei[14:12]));
        chk({tag, " funct7"}, 32'(funct7), 32'(ei[31:25]));
        chk({tag, " type3"}, 32'(type3), 32'(et));
        chk({tag, " illegal"}, 32'(illegal), 32'(eil));
        chk({tag, " fetch_err"}, 32'(fetch_err), 32'(exp_err));
    endtask

    // One full fetch transaction; rsp_dly >= TMO means the memory never answers.
    task automatic run_txn(input int req_dly, input int rsp_dly, input int hold_dly,
                           input logic [31:0] data, input logic [31:0] npc_v,
                           input logic [2:0] et_in, input logic eil_in, input string tag);
        logic        timed_out;
        logic [31:0] ei;
        logic [2:0]  et;
        logic        eil;
        logic [31:0] hold_pc;
        int          nwait;
        chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
        chk({tag, " addr"}, imem_addr, exp_pc);
        chk({tag, " out_valid_fetch"}, 32'(out_valid), 32'd0);
        chk({tag, " fetch_err_fetch"}, 32'(fetch_err), 32'(exp_err));
        for (int i = 0; i < req_dly; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            @(negedge clk);
            chk({tag, " req_pending_valid"}, 32'(imem_req_valid), 32'd1);
            chk({tag, " req_pending_addr"}, imem_addr, exp_pc);
            chk({tag, " out_valid_pending"}, 32'(out_valid), 32'd0);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk({tag, " req_accepted"}, 32'(imem_req_valid), 32'd0);
        chk({tag, " out_valid_wait"}, 32'(out_valid), 32'd0);
        timed_out = (rsp_dly >= TMO);
        nwait = timed_out ? TMO : rsp_dly + 1;
        for (int k = 0; k < nwait; k++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = !timed_out && (k == rsp_dly);
            imem_rsp_data  = imem_rsp_valid ? data : $urandom;
            @(negedge clk);
            if (k < nwait - 1) chk({tag, " out_valid_early"}, 32'(out_valid), 32'd0);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        if (timed_out) begin
            exp_err = 1'b1;
            ei = NOP; et = T_I; eil = 1'b0;
        end else begin
            ei = data; et = et_in; eil = eil_in;
        end
        hold_pc = exp_pc;
        check_hold(ei, et, eil, hold_pc, tag);
        for (int h = 0; h < hold_dly; h++) begin
            out_ready      = 1'b0;
            npc            = $urandom;
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            @(negedge clk);
            check_hold(ei, et, eil, hold_pc, {tag, " bp"});
        end
        out_ready      = 1'b1;
        npc            = npc_v;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        exp_pc = {npc_v[31:2], 2'b00};
    endtask

    initial begin
        logic [31:0] w;
        logic [2:0]  t;
        logic        il;

        vecs[0]  = '{32'h0050_0093, T_I, 1'b0};  // addi x1,x0,5
        vecs[1]  = '{32'h0020_a023, T_S, 1'b0};  // sw
        vecs[2]  = '{32'h0020_8063, T_B, 1'b0};  // beq
        vecs[3]  = '{32'h1234_50b7, T_U, 1'b0};  // lui
        vecs[4]  = '{32'h0000_00ef, T_J, 1'b0};  // jal
        vecs[5]  = '{32'h0020_81b3, T_R, 1'b0};  // add x3,x1,x2
        vecs[6]  = '{32'h0020_8833, T_R, 1'b1};  // add x16,x1,x2
        vecs[7]  = '{32'h0000_007f, T_R, 1'b1};  // unknown opcode
        vecs[8]  = '{32'h0008_0093, T_I, 1'b1};  // addi x1,x16,0
        vecs[9]  = '{32'h0100_a023, T_S, 1'b1};  // sw x16
        vecs[10] = '{32'h0000_0837, T_U, 1'b1};  // lui x16
        vecs[11] = '{32'h0000_086f, T_J, 1'b1};  // jal x16
        vecs[12] = '{32'h0020_8863, T_B, 1'b0};  // branch imm bits in rd slot
        vecs[13] = '{32'h0100_0093, T_I, 1'b0};  // addi imm bits in rs2 slot
        vecs[14] = '{32'h0000_0017, T_U, 1'b0};  // auipc x0

        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready = 1'b0;
        npc = '0;
        exp_pc = RST_PC;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset pc", pc, RST_PC);
        chk("reset inst", inst, NOP);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset fetch_err", 32'(fetch_err), 32'd0);
        chk("reset req_valid", 32'(imem_req_valid), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_txn(0, 0, 0, vecs[i].w, exp_pc + 32'd4, vecs[i].t, vecs[i].il,
                    $sformatf("vec%0d", i));

        run_txn(0, 0, 5, 32'h0020_81b3, 32'h8000_0010, T_R, 1'b0, "backpressure");
        chk("bp next addr", imem_addr, 32'h8000_0010);
        run_txn(2, 1, 1, 32'h0050_0093, 32'h8000_0023, T_I, 1'b0, "misaligned npc");
        chk("aligned addr", imem_addr, 32'h8000_0020);
        run_txn(0, TMO - 1, 0, 32'h0020_a023, 32'h8000_0100, T_S, 1'b0, "last-cycle rsp");
        chk("no err on last-cycle rsp", 32'(fetch_err), 32'd0);
        run_txn(1, 99, 2, 32'h0020_8833, 32'h8000_0200, T_R, 1'b1, "timeout");
        run_txn(0, 0, 0, 32'h1234_50b7, 32'h8000_0204, T_U, 1'b0, "after timeout");
        chk("fetch_err sticky", 32'(fetch_err), 32'd1);

        // reset while waiting for a response
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait out_valid", 32'(out_valid), 32'd0);
        chk("rst_wait pc", pc, RST_PC);
        chk("rst_wait req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_wait fetch_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RST_PC;
        exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hdead_beef;
            @(negedge clk);
            chk("late rsp ignored", 32'(out_valid), 32'd0);
        end
        imem_rsp_valid = 1'b0;
        chk("late rsp inst", inst, NOP);
        run_txn(0, 0, 0, 32'h0020_81b3, 32'h8000_0008, T_R, 1'b0, "post reset");

        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = OPS[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) < 7) begin
                w[11] = 1'b0;
                w[19] = 1'b0;
                w[24] = 1'b0;
            end
            ref_class(w, t, il);
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), w, $urandom, t, il, $sformatf("rnd%0d", n));
        end

        // reset while holding an instruction
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_81b3;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("pre rst_hold out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_hold out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold pc", pc, RST_PC);
        chk("rst_hold inst", inst, NOP);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_decode.md
# ifu_decode

Instruction fetch and field-split stage of the multicycle RV32E NPC. It owns the PC and fetches one instruction at a time over a valid/ready instruction-memory port. It latches the instruction and presents its register, funct and type fields to the immediate extender and the rest of decode. A new fetch starts only after downstream accepts the current instruction and returns the next PC.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles spent waiting for an instruction-memory response before `fetch_err`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address; always equals `pc`.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- out_valid  out  1  latched instruction and fields are valid.
- out_ready  in  1  downstream consumes the instruction this cycle.
- npc  in  32  next PC; sampled when `out_valid && out_ready`.
- pc  out  32  address of the latched instruction.
- inst  out  32  latched instruction.
- rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- type3  out  `TYPE_BUS` (3 bits)  instruction format class.
- illegal  out  1  unknown opcode, or RV32E register index ≥ 16.
- fetch_err  out  1  sticky; set on response timeout.

## Operation
- The FSM has three states: FETCH, WAIT and HOLD.
- **FETCH:**
  - `imem_req_valid` = 1.
  - When `imem_req_ready` is high, go to WAIT and clear the wait counter.
- **WAIT:**
  - The wait counter increments each cycle.
  - When `imem_rsp_valid` is high, `inst <= imem_rsp_data` and go to HOLD.
  - If the counter reaches TIMEOUT with no response:
    - set `fetch_err`;
    - load `inst` with 32'h0000_0013 (nop, addi x0,x0,0);
    - go to HOLD.
- **HOLD:**
  - `out_valid` = 1.
  - On `out_ready`:
    - `pc <= {npc[31:2], 2'b00}`, which forces alignment;
    - go to FETCH.
- `imem_rsp_valid` is ignored outside WAIT. `imem_req_ready` is ignored outside FETCH.
- Field outputs are combinational slices of the `inst` register. They are stable for the whole of HOLD.
- type3 decode from inst[6:0]:
  - 0110011 → INST_R
  - 0010011, 0000011, 1100111, 1110011 → INST_I
  - 0100011 → INST_S
  - 1100011 → INST_B
  - 0110111, 0010111 → INST_U
  - 1101111 → INST_J
  - any other opcode → INST_R with `illegal` = 1
- RV32E register check: `illegal` = 1 if bit 4 is set in any field the format uses:
  - R: rd, rs1, rs2
  - I: rd, rs1
  - S and B: rs1, rs2
  - U and J: rd
- `illegal` and `type3` are meaningful only while `out_valid` = 1.
- `fetch_err` clears only on reset.

## Timing
- **Reset values:**
  - state = FETCH
  - `pc` = RESET_PC
  - `inst` = 32'h0000_0013
  - `out_valid` = 0
  - `fetch_err` = 0
  - wait counter = 0
  - `imem_req_valid` = 1 immediately after reset, since it is decoded from state
- **Latency:**
  - With zero memory wait, the request is accepted in cycle 0 and the response arrives in cycle 1, so `out_valid` rises in cycle 2.
  - The minimum issue period is 3 cycles per instruction: FETCH, WAIT, HOLD, with `out_ready` held high.
- **Handshakes:**
  - `imem_req_valid` stays high until accepted.
  - `imem_addr` is stable while the request is pending.
  - `out_valid` stays high until `out_ready`; the outputs do not change while waiting.
- A response arriving in the same cycle the counter reaches TIMEOUT counts as a normal response. `fetch_err` is not set.
- Reset asserted mid-WAIT or mid-HOLD returns to the reset values asynchronously. A late response after reset is dropped because the FSM is in FETCH.
- `npc` with bits [1:0] ≠ 0 is silently aligned. The misaligned-PC exception is signalled downstream, not here.

## Structure
- `INST_R`..`INST_J` (values 0–5), `TYPE_BUS` (2:0), `RegBus` and the opcode constants belong in the shared defines header.
- The FSM state encoding stays local to this block.
- One natural sub-module is `inst_classify`: combinational logic mapping inst to type3 and illegal. It is reusable by the difftest checker.

## Test plan
- **Reset, zero-wait memory:**
  - Stimulus: release reset, tie ready and rsp_valid high, respond with 32'h00500093.
  - Required response: imem_addr = 0x8000_0000; out_valid in cycle 2; type3 = INST_I; rd = 1; rs1 = 0; illegal = 0.
- **Backpressure:**
  - Stimulus: hold out_ready low for 5 cycles in HOLD.
  - Required response: outputs frozen, no new request; after out_ready with npc = 0x8000_0010, imem_addr = 0x8000_0010 next cycle.
- **Opcode sweep:**
  - Stimulus: one instruction per class: sw, beq, lui, jal, add.
  - Required response: type3 = S, B, U, J, R respectively; illegal = 0.
- **RV32E / opcode violation:**
  - Stimulus: add x16,x1,x2 (32'h00208833).
  - Required response: illegal = 1.
  - Stimulus: opcode 1111111.
  - Required response: illegal = 1, type3 = INST_R.
- **Timeout (TIMEOUT = 4):**
  - Stimulus: never send rsp_valid.
  - Required response: HOLD entered after 4 WAIT cycles; inst = 0x00000013; fetch_err = 1 and stays set across subsequent fetches.
- **Async reset mid-WAIT:**
  - Stimulus: assert rst, then deliver rsp_valid while in FETCH.
  - Required response: out_valid = 0; response ignored; pc = RESET_PC.
